spi_slave_cmd_sequencer: RTL

//  Parametrised command front-end for the SPI slave, in the sclk domain. It replaces the

---
 rtl/spi_slave_pkg.sv | 44 ++++
 rtl/spi_slave_cmd_decode.sv | 63 ++++++
 rtl/spi_slave_cmd_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// ----------------------------------------------------------------------------
// spi_slave_pkg
//   Shared types and constants for the SPI slave command front-end.
//   - spi_seq_phase_e : sequencer phase encoding (also driven out on 'phase')
//   - opcode constants : low-nibble register opcodes and full memory opcodes
//   - spi_cmd_dec_t    : result of decoding one 8-bit opcode
//   - max3             : elaboration-time helper for sizing the bit counter
// ----------------------------------------------------------------------------
package spi_slave_pkg;

   typedef enum logic [2:0] {
      PH_CMD     = 3'd0,
      PH_ADDR    = 3'd1,
      PH_DUMMY   = 3'd2,
      PH_DATA_RX = 3'd3,
      PH_DATA_TX = 3'd4,
      PH_DONE    = 3'd5,
      PH_ERR     = 3'd6
   } spi_seq_phase_e;

   // Register opcodes carry the register index in the upper nibble.
   localparam logic [3:0] OP_WR_REG_LSN = 4'h1;
   localparam logic [3:0] OP_RD_REG_LSN = 4'h5;
   localparam logic [7:0] OP_RD_REG1    = 8'h07;
   localparam logic [7:0] OP_WR_MEM     = 8'h02;
   localparam logic [7:0] OP_RD_MEM     = 8'h0B;
   localparam logic [7:0] OP_QWR_MEM    = 8'h32;
   localparam logic [7:0] OP_QRD_MEM    = 8'h6B;

   typedef struct packed {
      logic       err;      // opcode not accepted
      logic       is_reg;   // register access (8-bit word, no address)
      logic       is_rd;    // slave drives data (DATA_TX)
      logic       quad;     // 4-lane address/data
      logic [3:0] reg_idx;  // register slot, 0 for memory opcodes
   } spi_cmd_dec_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_slave_cmd_decode.sv
// ----------------------------------------------------------------------------
// spi_slave_cmd_decode
//   Purely combinational opcode decoder.
//   Ports:
//     op  in  [7:0]          opcode (complete, MSB first already assembled)
//     dec out spi_cmd_dec_t  access type, lane mode, register slot, error flag
//   Register slots at or above N_REGS and quad opcodes with QUAD_EN==0 are
//   reported as errors; every other unlisted opcode is an error as well.
// ----------------------------------------------------------------------------
module spi_slave_cmd_decode
   import spi_slave_pkg::*;
#(
   parameter int N_REGS  = 4,
   parameter int QUAD_EN = 1
) (
   input  logic [7:0]   op,
   output spi_cmd_dec_t dec
);

   always_comb begin
      dec     = '0;
      dec.err = 1'b1;
      if (op[3:0] == OP_WR_REG_LSN) begin
         dec.err     = 1'b0;
         dec.is_reg  = 1'b1;
         dec.reg_idx = op[7:4];
      end else if (op[3:0] == OP_RD_REG_LSN) begin
         dec.err     = 1'b0;
         dec.is_reg  = 1'b1;
         dec.is_rd   = 1'b1;
         dec.reg_idx = op[7:4];
      end else if (op == OP_RD_REG1) begin
         dec.err     = 1'b0;
         dec.is_reg  = 1'b1;
         dec.is_rd   = 1'b1;
         dec.reg_idx = 4'd1;
      end else begin
         unique case (op)
            OP_WR_MEM:  dec.err = 1'b0;
            OP_RD_MEM:  begin dec.err = 1'b0; dec.is_rd = 1'b1; end
            OP_QWR_MEM: begin dec.err = 1'b0; dec.quad = 1'b1; end
            OP_QRD_MEM: begin dec.err = 1'b0; dec.quad = 1'b1; dec.is_rd = 1'b1; end
            default:    dec.err = 1'b1;
         endcase
      end

      if (dec.is_reg && (int'(dec.reg_idx) >= N_REGS)) begin
         dec.err = 1'b1;
      end
      if (dec.quad && (QUAD_EN == 0)) begin
         dec.err = 1'b1;
      end

      // A rejected opcode must not leak partial decode into the sequencer.
      if (dec.err) begin
         dec.is_reg  = 1'b0;
         dec.is_rd   = 1'b0;
         dec.quad    = 1'b0;
         dec.reg_idx = 4'd0;
      end
   end

endmodule

// File: rtl/spi_slave_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// spi_slave_cmd_sequencer
//   SPI slave command front-end in the sclk domain. Shifts in the opcode on
//   sdi[0], decodes it, then walks CMD -> ADDR -> DUMMY -> DATA and emits
//   per-edge strobes for the external rx/tx/address shifters.
//   Ports:
//     sclk, sys_rstn      clock (posedge) and async active-low reset
//     cs_n                sampled; high on an edge aborts back to CMD
//     sdi[3:0]            lane data (only sdi[0] is consumed here, for opcode)
//     cfg_dummy[7:0]      dummy edges for memory reads, sampled leaving ADDR
//     phase[2:0]          current spi_seq_phase_e
//     cmd, reg_sel,
//     is_reg, quad        captured opcode and decode, valid after CMD
//     addr_sample,
//     rx_sample, tx_shift Moore strobes: high in the cycle whose edge samples
//     addr_done,
//     word_done           1-cycle pulses after the last address bit / word bit
//     word_cnt            completed words, saturating
//     error               high while parked in ERR
// ----------------------------------------------------------------------------
module spi_slave_cmd_sequencer
   import spi_slave_pkg::*;
#(
   parameter int N_REGS  = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int CNT_W   = 16,
   parameter int QUAD_EN = 1,
   localparam int RS_W   = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
   input  logic              sclk,
   input  logic              sys_rstn,
   input  logic              cs_n,
   input  logic [3:0]        sdi,
   input  logic [7:0]        cfg_dummy,
   output logic [2:0]        phase,
   output logic [7:0]        cmd,
   output logic [RS_W-1:0]   reg_sel,
   output logic              is_reg,
   output logic              quad,
   output logic              addr_sample,
   output logic              addr_done,
   output logic              rx_sample,
   output logic              tx_shift,
   output logic              word_done,
   output logic [CNT_W-1:0]  word_cnt,
   output logic              error
);

   // Longest phase is a 255-edge dummy or a full single-lane address/word.
   localparam int MAX_LEN = max3(256, ADDR_W, DATA_W);
   localparam int BC_W    = $clog2(MAX_LEN);

   localparam logic [BC_W-1:0] CMD_LAST    = BC_W'(7);
   localparam logic [BC_W-1:0] REG_LAST    = BC_W'(7);
   localparam logic [BC_W-1:0] ADDR_LAST_S = BC_W'(ADDR_W - 1);
   localparam logic [BC_W-1:0] ADDR_LAST_Q = BC_W'(ADDR_W / 4 - 1);
   localparam logic [BC_W-1:0] DATA_LAST_S = BC_W'(DATA_W - 1);
   localparam logic [BC_W-1:0] DATA_LAST_Q = BC_W'(DATA_W / 4 - 1);

   spi_seq_phase_e    phase_q, phase_d;
   logic [BC_W-1:0]   cnt_q, cnt_d;
   logic [6:0]        sh_q, sh_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [RS_W-1:0]   reg_sel_q, reg_sel_d;
   logic              is_reg_q, is_reg_d;
   logic              is_rd_q, is_rd_d;
   logic              quad_q, quad_d;
   logic [7:0]        dummy_q, dummy_d;
   logic              addr_done_q, addr_done_d;
   logic              word_done_q, word_done_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

   logic [7:0]        op_full;
   spi_cmd_dec_t      dec;
   logic [BC_W-1:0]   addr_last;
   logic [BC_W-1:0]   word_last;
   logic              unused_ok;

   // The 8th opcode bit arrives on the decoding edge itself, so decode
   // looks at the shift register plus the live lane bit.
   assign op_full = {sh_q, sdi[0]};

   spi_slave_cmd_decode #(
      .N_REGS  (N_REGS),
      .QUAD_EN (QUAD_EN)
   ) u_decode (
      .op  (op_full),
      .dec (dec)
   );

   assign addr_last = quad_q ? ADDR_LAST_Q : ADDR_LAST_S;
   assign word_last = is_reg_q ? REG_LAST : (quad_q ? DATA_LAST_Q : DATA_LAST_S);

   always_comb begin
      phase_d     = phase_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      cmd_d       = cmd_q;
      reg_sel_d   = reg_sel_q;
      is_reg_d    = is_reg_q;
      is_rd_d     = is_rd_q;
      quad_d      = quad_q;
      dummy_d     = dummy_q;
      word_cnt_d  = word_cnt_q;
      addr_done_d = 1'b0;
      word_done_d = 1'b0;

      unique case (phase_q)
         PH_CMD: begin
            sh_d  = op_full[6:0];
            cnt_d = cnt_q + BC_W'(1);
            if (cnt_q == CMD_LAST) begin
               cnt_d = '0;
               cmd_d = op_full;
               if (dec.err) begin
                  phase_d = PH_ERR;
               end else begin
                  is_reg_d  = dec.is_reg;
                  is_rd_d   = dec.is_rd;
                  quad_d    = dec.quad;
                  reg_sel_d = dec.reg_idx[RS_W-1:0];
                  if (dec.is_reg) begin
                     phase_d = dec.is_rd ? PH_DATA_TX : PH_DATA_RX;
                  end else begin
                     phase_d = PH_ADDR;
                  end
               end
            end
         end

         PH_ADDR: begin
            cnt_d = cnt_q + BC_W'(1);
            if (cnt_q == addr_last) begin
               cnt_d       = '0;
               addr_done_d = 1'b1;
               if (!is_rd_q) begin
                  phase_d = PH_DATA_RX;
               end else if (cfg_dummy == 8'd0) begin
                  phase_d = PH_DATA_TX;
               end else begin
                  dummy_d = cfg_dummy;
                  phase_d = PH_DUMMY;
               end
            end
         end

         PH_DUMMY: begin
            cnt_d = cnt_q + BC_W'(1);
            if (cnt_q == BC_W'(dummy_q - 8'd1)) begin
               cnt_d   = '0;
               phase_d = PH_DATA_TX;
            end
         end

         PH_DATA_RX, PH_DATA_TX: begin
            cnt_d = cnt_q + BC_W'(1);
            if (cnt_q == word_last) begin
               // Memory bursts wrap the bit counter and run until abort.
               cnt_d       = '0;
               word_done_d = 1'b1;
               if (word_cnt_q != {CNT_W{1'b1}}) begin
                  word_cnt_d = word_cnt_q + CNT_W'(1);
               end
               if (is_reg_q) begin
                  phase_d = PH_DONE;
               end
            end
         end

         default: begin
            // DONE / ERR: park and ignore every edge.
         end
      endcase

      // Abort takes priority over any transition computed above; a partial
      // word is dropped without a word_done.
      if (cs_n) begin
         phase_d     = PH_CMD;
         cnt_d       = '0;
         sh_d        = '0;
         cmd_d       = '0;
         reg_sel_d   = '0;
         is_reg_d    = 1'b0;
         is_rd_d     = 1'b0;
         quad_d      = 1'b0;
         dummy_d     = '0;
         word_cnt_d  = '0;
         addr_done_d = 1'b0;
         word_done_d = 1'b0;
      end
   end

   always_ff @(posedge sclk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         phase_q     <= PH_CMD;
         cnt_q       <= '0;
         sh_q        <= '0;
         cmd_q       <= '0;
         reg_sel_q   <= '0;
         is_reg_q    <= 1'b0;
         is_rd_q     <= 1'b0;
         quad_q      <= 1'b0;
         dummy_q     <= '0;
         word_cnt_q  <= '0;
         addr_done_q <= 1'b0;
         word_done_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         cmd_q       <= cmd_d;
         reg_sel_q   <= reg_sel_d;
         is_reg_q    <= is_reg_d;
         is_rd_q     <= is_rd_d;
         quad_q      <= quad_d;
         dummy_q     <= dummy_d;
         word_cnt_q  <= word_cnt_d;
         addr_done_q <= addr_done_d;
         word_done_q <= word_done_d;
      end
   end

   assign phase       = phase_q;
   assign cmd         = cmd_q;
   assign reg_sel     = reg_sel_q;
   assign is_reg      = is_reg_q;
   assign quad        = quad_q;
   assign addr_sample = (phase_q == PH_ADDR);
   assign rx_sample   = (phase_q == PH_DATA_RX);
   assign tx_shift    = (phase_q == PH_DATA_TX);
   assign addr_done   = addr_done_q;
   assign word_done   = word_done_q;
   assign word_cnt    = word_cnt_q;
   assign error       = (phase_q == PH_ERR);

   // Upper lanes feed the external shifters only; upper reg_idx bits are
   // zero whenever the decode is accepted.
   assign unused_ok = ^{sdi[3:1], dec.reg_idx};

endmodule
